// File: rtl/btn_debounce_pkg.sv
// btn_debounce_pkg
//   Shared definitions for the push-button debouncer: FSM state encoding
//   and default qualification / long-press cycle counts.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  localparam int unsigned DEF_STABLE_COUNT = 1_000_000;
  localparam int unsigned DEF_LONG_COUNT   = 10_000_000;
  localparam int unsigned DEF_CNT_WIDTH    = 24;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous input pin.
//   Both stages clear to 0 on an asynchronous, active-high reset.
// Ports:
//   clk_i  destination clock
//   rst_i  asynchronous active-high reset
//   d_i    raw asynchronous input
//   q_o    synchronized output (second stage)
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce
//   Debounces one raw push-button / switch pin. Produces a clean level,
//   single-cycle rise/fall pulses, a single-cycle long-press pulse and an
//   8-bit wrapping count of accepted presses.
// Ports:
//   clk_out1_0   system clock
//   reset        asynchronous active-high reset
//   btn_in       raw asynchronous pin
//   btn_level    debounced level
//   btn_rise     one-cycle pulse on accepted 0->1
//   btn_fall     one-cycle pulse on accepted 1->0
//   long_press   one-cycle pulse once high has been held LONG_COUNT cycles
//   press_count  accepted rises, modulo 256
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = DEF_STABLE_COUNT,
  parameter int unsigned LONG_COUNT   = DEF_LONG_COUNT,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic       clk_out1_0,
  input  logic       reset,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_rise,
  output logic       btn_fall,
  output logic       long_press,
  output logic [7:0] press_count
);

  localparam logic [CNT_WIDTH-1:0] STAB_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_MAX  = CNT_WIDTH'(LONG_COUNT);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(LONG_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic                 btn_sync;
  state_t               state_q;
  logic [CNT_WIDTH-1:0] stab_q;
  logic [CNT_WIDTH-1:0] hold_q;
  logic                 level_q;
  logic                 rise_q;
  logic                 fall_q;
  logic                 long_q;
  logic [7:0]           count_q;

  sync_2ff u_sync (
    .clk_i (clk_out1_0),
    .rst_i (reset),
    .d_i   (btn_in),
    .q_o   (btn_sync)
  );

  always_ff @(posedge clk_out1_0 or posedge reset) begin
    if (reset) begin
      state_q <= LOW;
      stab_q  <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
      count_q <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      long_q <= 1'b0;

      // Hold time keeps accumulating while a release is being qualified, so a
      // release bounce does not disturb long-press timing. Saturation makes
      // the long-press pulse fire at most once per press.
      if ((state_q == HIGH) || (state_q == FALL_CHK)) begin
        if (hold_q < HOLD_MAX) begin
          hold_q <= hold_q + CNT_ONE;
          if (hold_q == HOLD_LAST) begin
            long_q <= 1'b1;
          end
        end
      end

      unique case (state_q)
        LOW: begin
          if (btn_sync) begin
            state_q <= RISE_CHK;
            stab_q  <= '0;
          end
        end

        RISE_CHK: begin
          if (!btn_sync) begin
            state_q <= LOW;
          end else if (stab_q == STAB_LAST) begin
            state_q <= HIGH;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
            count_q <= count_q + 8'd1;
            hold_q  <= '0;
          end else begin
            stab_q <= stab_q + CNT_ONE;
          end
        end

        HIGH: begin
          if (!btn_sync) begin
            state_q <= FALL_CHK;
            stab_q  <= '0;
          end
        end

        FALL_CHK: begin
          if (btn_sync) begin
            state_q <= HIGH;
          end else if (stab_q == STAB_LAST) begin
            state_q <= LOW;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            stab_q <= stab_q + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign btn_level   = level_q;
  assign btn_rise    = rise_q;
  assign btn_fall    = fall_q;
  assign long_press  = long_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;

  localparam int unsigned SC = 4;
  localparam int unsigned LC = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_in = 1'b0;
  logic       btn_level;
  logic       btn_rise;
  logic       btn_fall;
  logic       long_press;
  logic [7:0] press_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  btn_debounce #(
    .STABLE_COUNT (SC),
    .LONG_COUNT   (LC),
    .CNT_WIDTH    (24)
  ) dut (
    .clk_out1_0  (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_rise    (btn_rise),
    .btn_fall    (btn_fall),
    .long_press  (long_press),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the FSM samples the pin two edges late; the level
  // flips once the sampled pin has disagreed with it for SC+1 consecutive
  // edges. Long press fires LC edges after the rise edge if the level was
  // still high going into that edge.
  logic m_s1 = 1'b0, m_s2 = 1'b0;
  logic m_level = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_long = 1'b0;
  int   m_run = 0, m_count = 0, m_edge = 0, m_rise_edge = 0;

  always @(posedge clk or posedge reset) begin
    logic smp, nl, r, f, lp;
    int   run, cnt, re;
    if (reset) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_level <= 1'b0;
      m_rise <= 1'b0; m_fall <= 1'b0; m_long <= 1'b0;
      m_run <= 0; m_count <= 0; m_edge <= 0; m_rise_edge <= 0;
    end else begin
      smp = m_s2; nl = m_level; run = m_run; cnt = m_count; re = m_rise_edge;
      r = 1'b0; f = 1'b0; lp = 1'b0;
      if (smp != m_level) run = run + 1;
      else run = 0;
      if (run == int'(SC) + 1) begin
        nl  = ~m_level;
        run = 0;
        if (nl) begin
          r   = 1'b1;
          cnt = (cnt + 1) % 256;
          re  = m_edge;
        end else begin
          f = 1'b1;
        end
      end
      if (m_level && (m_edge - m_rise_edge == int'(LC))) lp = 1'b1;
      m_s1 <= btn_in; m_s2 <= m_s1;
      m_level <= nl; m_run <= run; m_count <= cnt; m_rise_edge <= re;
      m_rise <= r; m_fall <= f; m_long <= lp;
      m_edge <= m_edge + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("level", btn_level, m_level);
      check("rise", btn_rise, m_rise);
      check("fall", btn_fall, m_fall);
      check("long", long_press, m_long);
      check("count", press_count, m_count);
    end
  end

  initial begin
    int unsigned len;

    @(posedge clk);
    chk_en = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_level", btn_level, 0);
    check("rst_count", press_count, 0);
    check("rst_pulses", {btn_rise, btn_fall, long_press}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_level", btn_level, 0);

    // Clean press: rise exactly SC+2 edges after first high sample
    btn_in = 1'b1;
    repeat (6) @(negedge clk);
    check("press_early_level", btn_level, 0);
    check("press_early_rise", btn_rise, 0);
    @(negedge clk);
    check("press_level", btn_level, 1);
    check("press_rise", btn_rise, 1);
    check("press_count1", press_count, 1);
    @(negedge clk);
    check("press_rise_off", btn_rise, 0);

    // Long press: pulse exactly LC edges after the rise edge, once
    repeat (14) @(negedge clk);
    check("long_early", long_press, 0);
    @(negedge clk);
    check("long_fire", long_press, 1);
    @(negedge clk);
    check("long_once", long_press, 0);
    repeat (13) @(negedge clk);
    btn_in = 1'b0;
    repeat (6) @(negedge clk);
    check("rel_early_level", btn_level, 1);
    check("rel_early_fall", btn_fall, 0);
    @(negedge clk);
    check("rel_level", btn_level, 0);
    check("rel_fall", btn_fall, 1);

    // Reset while qualifying a second press
    btn_in = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_count", press_count, 0);
    check("async_rst_level", btn_level, 0);
    btn_in = 1'b0;
    repeat (2) @(negedge clk);
    #3 reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_level", btn_level, 0);
    check("post_rst_count", press_count, 0);

    // Press bounce: runs shorter than SC+1 never accepted
    btn_in = 1'b1; repeat (3) @(negedge clk);
    btn_in = 1'b0; repeat (1) @(negedge clk);
    btn_in = 1'b1; repeat (3) @(negedge clk);
    btn_in = 1'b0; repeat (10) @(negedge clk);
    check("bounce_count", press_count, 0);
    check("bounce_level", btn_level, 0);

    // Release glitch while held: no fall, long-press timing unchanged
    btn_in = 1'b1;
    repeat (7) @(negedge clk);
    check("glitch_rise", btn_rise, 1);
    repeat (3) @(negedge clk);
    btn_in = 1'b0;
    repeat (2) @(negedge clk);
    btn_in = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch_long_early", long_press, 0);
    @(negedge clk);
    check("glitch_long", long_press, 1);
    check("glitch_level", btn_level, 1);
    btn_in = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_released", btn_level, 0);

    // Randomized segments with occasional asynchronous resets
    for (int seg = 0; seg < 400; seg++) begin
      btn_in = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 12);
      repeat (len) @(negedge clk);
      if ($urandom_range(0, 60) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
      end
    end

    // Wrap: 257 clean presses from reset
    btn_in = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 257; p++) begin
      btn_in = 1'b1; repeat (8) @(negedge clk);
      btn_in = 1'b0; repeat (8) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("wrap_count", press_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
